ifetch_queue: RTL
=================

# ifetch_queue

Instruction prefetch queue between instruction memory and the IF/ID stage of the 16-bit pipelined CPU. It generates sequential fetch addresses and issues them to instruction memory over a req/ack handshake with variable latency. Returned instruction words are buffered in a small FIFO, and the head is presented to the IF/ID register. A taken-branch redirect from EX/MEM flushes the queue and restarts fetch at the target.

## Interface
- DEPTH, 4, queue entries (power of two, ≥2)
- ADDR_W, 16, byte-address width
- INSTR_W, 16, instruction width
- clock  in  1  pipeline clock; all state updates on falling edge
- reset  in  1  synchronous, active-high
- redirect  in  1  taken branch/bne/beq resolved in EX/MEM
- redirect_pc  in  ADDR_W  branch target (byte address, even)
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_W  byte address of the request
- imem_ack  in  1  memory returns data for the current request
- imem_rdata  in  INSTR_W  instruction word, valid with imem_ack
- ir_valid  out  1  queue head valid
- ir  out  INSTR_W  head instruction; 16'h0000 (nop) when ir_valid=0
- ir_pc  out  ADDR_W  byte address of head instruction; 0 when empty
- ir_ready  in  1  IF/ID consumes head this edge (stall when 0)
- count  out  $clog2(DEPTH)+1  occupied entries

## Operation
- Registers: fetch_pc, FIFO (instr + pc per entry), rd/wr pointers, count, state.
- Reset: fetch_pc=0, count=0, state IDLE, imem_req=0, imem_addr=0, ir_valid=0, ir=0, ir_pc=0.
- FSM:
  - IDLE: imem_req=0. Go to REQ when count<DEPTH.
  - REQ: imem_req=1, imem_addr=fetch_pc, held stable until ack.
    - On ack: push {imem_rdata, fetch_pc} and set fetch_pc+=2.
    - Next state is REQ if the post-edge count<DEPTH, else IDLE.
  - DRAIN: imem_req=1 on the abandoned address, held until ack.
    - On ack: discard data, go to REQ with the stored target.
- The handshake cannot be abandoned. At most one request is outstanding.
- imem_ack may arrive in the same cycle imem_req is first high (zero-wait memory gives one fetch per cycle).
- Pop: ir_valid & ir_ready advances rd_ptr. ir_ready with ir_valid=0 is ignored. Push and pop on the same edge leave count unchanged.
- Redirect (priority below reset, above everything else):
  - Flush FIFO (count=0, pointers equal) and set fetch_pc=redirect_pc.
  - In REQ without ack, go to DRAIN.
  - In REQ with ack the same edge, discard the data and go to REQ.
  - In IDLE, go to REQ.
  - In DRAIN, overwrite the target and stay in DRAIN (newest redirect wins).
  - A pop coinciding with redirect is a no-op.
- Arithmetic: fetch_pc increments mod 2^ADDR_W; 16'hFFFE+2=16'h0000. redirect_pc bit 0 is ignored (forced 0).
- Reset mid-request drops the outstanding request. Instruction memory shares the same reset.

## Timing
- Outputs ir/ir_pc/ir_valid/count are combinational from registers only, with no input-to-output paths. imem_req/imem_addr are registered state.
- Sequential fetch, zero-wait memory:
  - Request launched after edge n, acked at edge n+1, ir_valid after edge n+1.
  - Sustained throughput is 1 instr/cycle while count<DEPTH.
- Redirect to first valid target instruction, zero-wait memory: 2 edges (redirect edge, ack edge).
- Redirect with a pending request: add the remaining wait states of that request plus one.
- Full: imem_req drops the edge after the push that fills the queue. It re-asserts the edge after the first pop.

## Structure
- Shared package `ifq_pkg`:
  - INSTR_W=16, ADDR_W=16
  - NOP_INSTR=16'h0000, PC_STEP=2
  - FSM encoding IDLE/REQ/DRAIN
- Sub-module `fetch_fifo`: DEPTH-entry circular buffer holding {instr, pc}, with push/pop/flush, FWFT head and count. The top level holds the FSM and fetch_pc.

## Test plan
- Reset, zero-wait memory returning word addr>>1, ir_ready=1 → imem_addr 0,2,4,6… on consecutive cycles; ir/ir_pc stream in order; ir=0 before the first ack.
- ir_ready=0 → count reaches 4 and imem_req=0 with fetch_pc=8. One pop → req re-asserts at addr 8, count returns to 4.
- Redirect to 0x0020 while full/IDLE → count=0, ir_valid=0, ir=0 next cycle. Next imem_addr=0x0020; first ir_pc=0x0020.
- 3-wait-state memory, redirect to 0x0040 while addr 6 is pending → imem_addr stays 6 until ack; that word never appears on ir. Then req 0x0040, first ir_pc=0x0040. A second redirect to 0x0060 during DRAIN → first ir_pc=0x0060.
- Redirect on the same edge as ack → acked word discarded, no DRAIN, next imem_addr=redirect_pc.
- Redirect to 0xFFFC → addresses FFFC, FFFE, 0000, 0002. Assert reset mid-request → all outputs at reset values the next cycle, fetch restarts at 0.

Source files
------------

// File: rtl/ifq_pkg.sv
// Shared widths, constants and FSM encoding for the instruction prefetch queue.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ifq_pkg;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 16;

  localparam logic [15:0] NOP_INSTR = 16'h0000;
  localparam int          PC_STEP   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } ifq_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of {instr, pc} with first-word-fall-through head and flush.
// Latency: a pushed entry is visible at the head right after the falling edge that writes it.
// Backpressure: pushes while full and pops while empty are ignored; flush beats push and pop.
module fetch_fifo #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               push,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic [ADDR_W-1:0]  push_pc,
  input  logic               pop,
  output logic               head_valid,
  output logic [INSTR_W-1:0] head_instr,
  output logic [ADDR_W-1:0]  head_pc,
  output logic [CNT_W-1:0]   count
);
  import ifq_pkg::*;

  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0]  pc_mem    [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               do_push;
  logic               do_pop;

  assign do_push = push && (count != CNT_W'(DEPTH));
  assign do_pop  = pop && (count != '0);

  // Pointers and occupancy; flush empties the buffer by re-aligning both pointers.
  always_ff @(negedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents need no reset because occupancy qualifies every read.
  always_ff @(negedge clock) begin
    if (do_push && !flush && !reset) begin
      instr_mem[wr_ptr] <= push_instr;
      pc_mem[wr_ptr]    <= push_pc;
    end
  end

  // Head is driven from registers only; an empty queue presents a nop at pc 0.
  always_comb begin
    head_valid = (count != '0);
    head_instr = head_valid ? instr_mem[rd_ptr] : INSTR_W'(NOP_INSTR);
    head_pc    = head_valid ? pc_mem[rd_ptr] : '0;
  end

endmodule

// File: rtl/ifetch_queue.sv
// Sequential instruction prefetcher feeding IF/ID, with branch-redirect flush.
// Latency: zero-wait memory gives ir_valid one falling edge after the request launches; 1 instr/cycle sustained.
// Backpressure: ir_ready=0 holds the head; the request stops once the queue fills and resumes after a pop.
module ifetch_queue #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = ifq_pkg::ADDR_W,
  parameter int INSTR_W = ifq_pkg::INSTR_W,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               ir_valid,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc,
  input  logic               ir_ready,
  output logic [CNT_W-1:0]   count
);
  import ifq_pkg::*;

  ifq_state_e        state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] target_pc;
  logic [ADDR_W-1:0] next_pc;
  logic              push;
  logic              pop;
  logic [CNT_W-1:0]  count_after;

  // Instructions are halfword aligned, so the low target bit is meaningless.
  assign target_pc   = {redirect_pc[ADDR_W-1:1], 1'b0};
  assign next_pc     = fetch_pc + ADDR_W'(PC_STEP);
  // A redirect flushes the queue, so neither the acked word nor a pop survives it.
  assign push        = (state == REQ) && imem_ack && !redirect;
  assign pop         = ir_valid && ir_ready && !redirect;
  assign count_after = count + CNT_W'(push) - CNT_W'(pop);

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .flush      (redirect),
    .push       (push),
    .push_instr (imem_rdata),
    .push_pc    (fetch_pc),
    .pop        (pop),
    .head_valid (ir_valid),
    .head_instr (ir),
    .head_pc    (ir_pc),
    .count      (count)
  );

  // Fetch FSM: fetch_pc is the in-flight address in REQ and the pending target in DRAIN.
  always_ff @(negedge clock) begin
    if (reset) begin
      state     <= IDLE;
      fetch_pc  <= '0;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else if (redirect) begin
      fetch_pc <= target_pc;
      imem_req <= 1'b1;
      // An unacked request cannot be withdrawn, so keep its address up and discard its data later.
      // A request that acks on this very edge is complete, so fetch restarts at the target directly.
      if ((state != IDLE) && !imem_ack) begin
        state <= DRAIN;
      end else begin
        state     <= REQ;
        imem_addr <= target_pc;
      end
    end else begin
      case (state)
        IDLE: begin
          if (count < CNT_W'(DEPTH)) begin
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc;
          end
        end
        REQ: begin
          if (imem_ack) begin
            fetch_pc  <= next_pc;
            imem_addr <= next_pc;
            if (count_after < CNT_W'(DEPTH)) begin
              state <= REQ;
            end else begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            state     <= REQ;
            imem_addr <= fetch_pc;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
